// File: rtl/csma_pkg.sv
// Shared definitions for the CSMA/CA channel-access engine.
package csma_pkg;

  localparam int unsigned LFSR_WIDTH = 16;
  localparam int unsigned CW_EXP_MAX = 10;

  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
  // Feedback taps for x^16+x^14+x^13+x^11+1, bit positions 15,13,12,10
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IFS = 2'd1,
    ST_BACKOFF  = 2'd2,
    ST_GRANT    = 2'd3
  } csma_state_e;

  // Contention-window exponent limited to CW_EXP_MAX
  function automatic logic [3:0] clamp_cw(input logic [3:0] cw);
    return (cw > 4'(CW_EXP_MAX)) ? 4'(CW_EXP_MAX) : cw;
  endfunction

endpackage

// File: rtl/csma_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the backoff random source.
module csma_lfsr
  import csma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output logic [LFSR_WIDTH-1:0] lfsr
);

  logic fb;

  assign fb = ^(lfsr & LFSR_TAPS);

  // Advance every cycle; the all-zero lock-up state is never kept
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (lfsr == '0) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[LFSR_WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/csma_backoff.sv
// CSMA/CA channel-access engine: IFS wait, slotted random backoff, grant.
// Optional feature macro: CSMA_EIFS_EN selects EIFS after a bad FCS.
module csma_backoff
  import csma_pkg::*;
#(
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned IFS_WIDTH  = 8,
  parameter int unsigned SLOT_WIDTH = 6,
  parameter int unsigned BO_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ch_idle,
  input  logic                  tx_req,
  input  logic                  tx_abort,
  input  logic                  tx_done,
  input  logic [3:0]            cw_exp,
  input  logic [IFS_WIDTH-1:0]  difs_top,
  input  logic [IFS_WIDTH-1:0]  eifs_top,
  input  logic [SLOT_WIDTH-1:0] slot_top,
  input  logic                  fcs_in_strobe,
  input  logic                  fcs_ok,
  output logic                  tx_grant,
  output logic                  access_busy,
  output logic [BO_WIDTH-1:0]   bo_remaining
);

  localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  csma_state_e             state;
  logic [PRE_W-1:0]        prescaler;
  logic [IFS_WIDTH-1:0]    ifs_cnt;
  logic [SLOT_WIDTH-1:0]   slot_cnt;
  logic [LFSR_WIDTH-1:0]   lfsr;
  logic [IFS_WIDTH-1:0]    ifs_sel;
  logic [SLOT_WIDTH-1:0]   slot_eff;
  logic [BO_WIDTH-1:0]     bo_mask;
  logic [BO_WIDTH-1:0]     bo_seed;
  logic                    us_tick;
  logic                    ifs_done;
  logic                    slot_last;

  csma_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

`ifdef CSMA_EIFS_EN
  logic eifs_flag;

  // Remember whether the most recent reception ended with a bad FCS
  always_ff @(posedge clk) begin
    if (rst) begin
      eifs_flag <= 1'b0;
    end else if (fcs_in_strobe) begin
      eifs_flag <= ~fcs_ok;
    end
  end

  assign ifs_sel = eifs_flag ? eifs_top : difs_top;
`else
  logic unused_eifs;

  assign unused_eifs = ^{fcs_in_strobe, fcs_ok, eifs_top};
  assign ifs_sel     = difs_top;
`endif

  logic unused_lfsr;

  assign unused_lfsr = ^lfsr;
  assign bo_seed     = lfsr[BO_WIDTH-1:0];
  assign bo_mask     = BO_WIDTH'((32'd1 << clamp_cw(cw_exp)) - 32'd1);
  assign us_tick     = (prescaler == PRE_W'(CLK_PER_US - 1));
  assign slot_eff    = (slot_top == '0) ? SLOT_WIDTH'(1) : slot_top;
  assign slot_last   = (slot_cnt == slot_eff - SLOT_WIDTH'(1));
  // An IFS of zero completes on the first idle cycle without waiting for a tick
  assign ifs_done    = (ifs_sel == '0) ||
                       (us_tick && (ifs_cnt == ifs_sel - IFS_WIDTH'(1)));

  // Access FSM with prescaler, IFS/slot counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      tx_grant     <= 1'b0;
      access_busy  <= 1'b0;
      bo_remaining <= '0;
      prescaler    <= '0;
      ifs_cnt      <= '0;
      slot_cnt     <= '0;
    end else begin
      prescaler <= us_tick ? '0 : prescaler + PRE_W'(1);
      case (state)
        ST_IDLE: begin
          if (tx_req) begin
            bo_remaining <= bo_seed & bo_mask;
            prescaler    <= '0;
            ifs_cnt      <= '0;
            access_busy  <= 1'b1;
            state        <= ST_WAIT_IFS;
          end
        end
        ST_WAIT_IFS: begin
          if (tx_abort) begin
            state        <= ST_IDLE;
            access_busy  <= 1'b0;
            bo_remaining <= '0;
          end else if (!ch_idle) begin
            ifs_cnt   <= '0;
            prescaler <= '0;
          end else if (ifs_done) begin
            ifs_cnt <= '0;
            if (bo_remaining == '0) begin
              state    <= ST_GRANT;
              tx_grant <= 1'b1;
            end else begin
              slot_cnt <= '0;
              state    <= ST_BACKOFF;
            end
          end else if (us_tick) begin
            ifs_cnt <= ifs_cnt + IFS_WIDTH'(1);
          end
        end
        ST_BACKOFF: begin
          if (tx_abort) begin
            state        <= ST_IDLE;
            access_busy  <= 1'b0;
            bo_remaining <= '0;
          end else if (!ch_idle) begin
            // Freeze the slot count and re-run the full IFS once idle again
            ifs_cnt   <= '0;
            prescaler <= '0;
            state     <= ST_WAIT_IFS;
          end else if (us_tick) begin
            if (slot_last) begin
              slot_cnt     <= '0;
              bo_remaining <= bo_remaining - BO_WIDTH'(1);
              if (bo_remaining == BO_WIDTH'(1)) begin
                state    <= ST_GRANT;
                tx_grant <= 1'b1;
              end
            end else begin
              slot_cnt <= slot_cnt + SLOT_WIDTH'(1);
            end
          end
        end
        ST_GRANT: begin
          if (tx_abort || tx_done) begin
            state        <= ST_IDLE;
            tx_grant     <= 1'b0;
            access_busy  <= 1'b0;
            bo_remaining <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
